// File: rtl/cordic_vec_scheduler_pkg.sv
// cordic_vec_scheduler_pkg: widths and helpers shared by the CORDIC scheduler slice.
package cordic_vec_scheduler_pkg;

  localparam int unsigned WORD_WIDTH     = 16;
  localparam int unsigned PHASE_WIDTH    = 16;  // unsigned U(9,7) degrees
  localparam int unsigned ITERATIONS     = 16;
  localparam int unsigned CORDIC_LATENCY = ITERATIONS - 1;

  typedef logic [WORD_WIDTH-1:0]  word_t;
  typedef logic [PHASE_WIDTH-1:0] phase_t;

  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/cordic_vec_scheduler_if.sv
// cordic_vec_scheduler_if: requester operand bus and result bus of the CORDIC scheduler.
interface cordic_vec_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  import cordic_vec_scheduler_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_x;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_y;
  logic                          res_valid;
  logic [ID_W-1:0]               res_id;
  phase_t                        res_phase;

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready, res_valid, res_id, res_phase
  );

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready, res_valid, res_id, res_phase
  );

endinterface

// File: rtl/cordic_vec_scheduler_rr_arbiter.sv
// cordic_vec_scheduler_rr_arbiter: combinational round-robin pick, scanning from i_rr_ptr upward.
module cordic_vec_scheduler_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_grant_any
);

  logic [ID_W-1:0] w_idx;

  // First eligible requester at or after the pointer wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    w_idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((32'(i_rr_ptr) + k) % NUM_REQ);
      if (!o_grant_any && i_eligible[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        o_grant_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_vec_scheduler.sv
// cordic_vec_scheduler: shares one pipelined vectoring CORDIC among NUM_REQ requesters with
// round-robin arbitration, an in-flight tag pipe and per-requester credit limits.
// Optional statistics counters: define CORDIC_SCHED_STATS_EN.
module cordic_vec_scheduler
  import cordic_vec_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned PIPE_LATENCY = CORDIC_LATENCY,
  parameter int unsigned MAX_OUT      = 4,
  parameter int unsigned ID_W         = id_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  cordic_vec_scheduler_if.slave io_bus,
  output word_t                 o_cor_x,
  output word_t                 o_cor_y,
  input  phase_t                i_cor_z
`ifdef CORDIC_SCHED_STATS_EN
  ,
  output logic [31:0]           o_stat_ops,
  output logic [31:0]           o_stat_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [ID_W-1:0]         r_rr_ptr;
  word_t                   r_cor_x, r_cor_y;
  logic [CNT_W-1:0]        r_cnt [NUM_REQ];
  logic [PIPE_LATENCY-1:0] r_tag_vld;
  logic [ID_W-1:0]         r_tag_id [PIPE_LATENCY];
  logic                    r_res_valid;
  logic [ID_W-1:0]         r_res_id;
  phase_t                  r_res_phase;

  logic [NUM_REQ-1:0] w_eligible, w_grant, w_inc, w_dec;
  logic [ID_W-1:0]    w_grant_idx, w_next_ptr, w_issue_id;
  logic               w_grant_any, w_accept, w_issue;
  word_t              w_sel_x, w_sel_y;

  // A requester competes only while it has credit left.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = io_bus.req_valid[i] & (r_cnt[i] < CNT_W'(MAX_OUT));
    end
  end

  cordic_vec_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_eligible  (w_eligible),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_any (w_grant_any)
  );

  // Reset also blocks accepts so nothing is taken while state is being cleared.
  assign w_accept         = w_grant_any & ~i_flush & rst_n;
  assign io_bus.req_ready = w_grant & {NUM_REQ{~i_flush & rst_n}};
  assign w_issue          = r_tag_vld[PIPE_LATENCY-1];
  assign w_issue_id       = r_tag_id[PIPE_LATENCY-1];
  assign w_next_ptr       = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
  assign w_inc            = w_grant & {NUM_REQ{w_accept}};

  // Operand mux and per-requester credit return decode.
  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    w_dec   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_x = io_bus.req_x[i*WORD_WIDTH +: WORD_WIDTH];
        w_sel_y = io_bus.req_y[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    if (w_issue) w_dec[w_issue_id] = 1'b1;
  end

  // Operand registers and round-robin pointer advance only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_cor_x  <= '0;
      r_cor_y  <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_next_ptr;
      r_cor_x  <= w_sel_x;
      r_cor_y  <= w_sel_y;
    end
  end

  // Tag pipe mirrors the CORDIC stages; it never stalls and flush drops every tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int s = 0; s < PIPE_LATENCY; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_vld   <= {r_tag_vld[PIPE_LATENCY-2:0], w_accept} & {PIPE_LATENCY{~i_flush}};
      r_tag_id[0] <= w_grant_idx;
      for (int s = 1; s < PIPE_LATENCY; s++) r_tag_id[s] <= r_tag_id[s-1];
    end
  end

  // Credit counters: accept takes one, result issue returns one; both at once cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_inc[i] && !w_dec[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  // Result register captures the CORDIC phase when the oldest tag is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_phase <= '0;
    end else begin
      r_res_valid <= w_issue & ~i_flush;
      if (w_issue && !i_flush) begin
        r_res_id    <= w_issue_id;
        r_res_phase <= i_cor_z;
      end
    end
  end

  assign o_cor_x          = r_cor_x;
  assign o_cor_y          = r_cor_y;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.res_id    = r_res_id;
  assign io_bus.res_phase = r_res_phase;

`ifdef CORDIC_SCHED_STATS_EN
  logic [31:0] r_stat_ops, r_stat_stall;

  // Free-running wrap-around counters; flush does not touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_ops   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_accept) r_stat_ops <= r_stat_ops + 32'd1;
      if ((|io_bus.req_valid) && !w_accept) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign o_stat_ops   = r_stat_ops;
  assign o_stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_cordic_vec_scheduler.sv
// tb_cordic_vec_scheduler: directed and randomized checks of the scheduler against a
// queue-based reference model; a behavioural stand-in provides the CORDIC phase.
module tb_cordic_vec_scheduler;
  import cordic_vec_scheduler_pkg::*;

  localparam int NR   = 4;
  localparam int LAT  = 15;
  localparam int MAXO = 4;

  logic   clk = 1'b0;
  logic   rst_n = 1'b1;
  logic   flush = 1'b0;
  word_t  cor_x, cor_y;
  phase_t cor_z;

  always #5 clk = ~clk;

  cordic_vec_scheduler_if #(.NUM_REQ(NR), .ID_W(2)) bus ();

`ifdef CORDIC_SCHED_STATS_EN
  logic [31:0] stat_ops, stat_stall;
`endif

  cordic_vec_scheduler #(
    .NUM_REQ      (NR),
    .PIPE_LATENCY (LAT),
    .MAX_OUT      (MAXO),
    .ID_W         (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .io_bus  (bus),
    .o_cor_x (cor_x),
    .o_cor_y (cor_y),
    .i_cor_z (cor_z)
`ifdef CORDIC_SCHED_STATS_EN
    ,
    .o_stat_ops   (stat_ops),
    .o_stat_stall (stat_stall)
`endif
  );

  // Exact vectoring result: atan2 in degrees, 0..360, scaled by 128.
  function automatic logic [15:0] phase_of(input logic [15:0] x, input logic [15:0] y);
    int  xi, yi;
    real a;
    xi = $signed(x);
    yi = $signed(y);
    a  = $atan2($itor(yi), $itor(xi)) * 180.0 / 3.14159265358979;
    if (a < 0.0) a = a + 360.0;
    return 16'($rtoi(a * 128.0 + 0.5));
  endfunction

  // CORDIC stand-in: z_out follows the registered operands by LAT-1 stages.
  phase_t cz_pipe [LAT-1];
  always @(posedge clk) begin
    cz_pipe[0] <= phase_of(cor_x, cor_y);
    for (int k = 1; k < LAT - 1; k++) cz_pipe[k] <= cz_pipe[k-1];
  end
  assign cor_z = cz_pipe[LAT-2];

  typedef struct {
    int          due;
    int          id;
    logic [15:0] ph;
  } exp_t;

  exp_t        m_q[$];
  int          m_ptr, m_cycle, m_ops, m_stall;
  int          n_checks, n_errors;
  word_t       dx[NR], dy[NR];
  int          log_acc_cyc[$], log_acc_id[$], log_res_cyc[$];
  logic [15:0] log_res_ph[$];
  int          base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    log_acc_cyc.delete();
    log_acc_id.delete();
    log_res_cyc.delete();
    log_res_ph.delete();
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic [NR-1:0] v, input logic fl);
    logic          exp_v;
    logic [NR-1:0] exp_rdy;
    int            cnt[NR];
    int            g, idx;
    @(negedge clk);
    bus.req_valid = v;
    flush         = fl;
    for (int i = 0; i < NR; i++) begin
      bus.req_x[i*16 +: 16] = dx[i];
      bus.req_y[i*16 +: 16] = dy[i];
    end
    #1;
    exp_v = (m_q.size() != 0) && (m_q[0].due == m_cycle);
    check("res_valid", 32'(bus.res_valid), 32'(exp_v));
    if (bus.res_valid === 1'b1) begin
      log_res_cyc.push_back(m_cycle);
      log_res_ph.push_back(bus.res_phase);
    end
    if (exp_v) begin
      check("res_id", 32'(bus.res_id), 32'(m_q[0].id));
      check("res_phase", 32'(bus.res_phase), 32'(m_q[0].ph));
      void'(m_q.pop_front());
    end
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    foreach (m_q[k]) cnt[m_q[k].id]++;
    exp_rdy = '0;
    g       = -1;
    if (!fl) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (g < 0 && v[idx] && cnt[idx] < MAXO) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    for (int i = 0; i < NR; i++) begin
      if (bus.req_ready[i] && v[i]) begin
        log_acc_cyc.push_back(m_cycle);
        log_acc_id.push_back(i);
      end
    end
    if (g >= 0) begin
      m_q.push_back('{m_cycle + LAT + 1, g, phase_of(dx[g], dy[g])});
      m_ptr = (g + 1) % NR;
      m_ops++;
    end else if (v != '0) begin
      m_stall++;
    end
    if (fl) m_q.delete();
    m_cycle++;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.req_valid = '1;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_id", 32'(bus.res_id), 32'd0);
    check("rst_res_phase", 32'(bus.res_phase), 32'd0);
    check("rst_cor_x", 32'(cor_x), 32'd0);
    check("rst_cor_y", 32'(cor_y), 32'd0);
    repeat (n) @(negedge clk);
    rst_n         = 1'b1;
    bus.req_valid = '0;
    m_q.delete();
    m_ptr   = 0;
    m_ops   = 0;
    m_stall = 0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; m_cycle = 0; m_ptr = 0; m_ops = 0; m_stall = 0;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    for (int i = 0; i < NR; i++) begin
      dx[i] = '0;
      dy[i] = '0;
    end
    do_reset(2);

    // Single op from requester 0: latency and 45 degrees.
    clear_logs();
    dx[0] = 16'd100; dy[0] = 16'd100;
    step(4'b0001, 1'b0);
    repeat (20) step(4'b0000, 1'b0);
    check("t1_nacc", 32'(log_acc_cyc.size()), 32'd1);
    check("t1_nres", 32'(log_res_cyc.size()), 32'd1);
    if (log_acc_cyc.size() > 0 && log_res_cyc.size() > 0) begin
      check("t1_latency", 32'(log_res_cyc[0] - log_acc_cyc[0]), 32'd16);
      check("t1_phase", 32'(log_res_ph[0]), 32'h1680);
    end

    // All requesters valid: strict rotation, 135 degrees.
    do_reset(2);
    clear_logs();
    for (int i = 0; i < NR; i++) begin
      dx[i] = 16'hFF9C; dy[i] = 16'd100;
    end
    repeat (8) step(4'b1111, 1'b0);
    repeat (20) step(4'b0000, 1'b0);
    check("t2_nacc", 32'(log_acc_id.size()), 32'd8);
    for (int k = 0; k < log_acc_id.size(); k++) check("t2_grant", 32'(log_acc_id[k]), 32'(k % NR));
    if (log_res_ph.size() > 0) check("t2_phase", 32'(log_res_ph[0]), 32'h4380);

    // Credit limit on one requester.
    do_reset(2);
    clear_logs();
    base  = m_cycle;
    dx[2] = 16'd300; dy[2] = 16'hFFCE;
    repeat (20) step(4'b0100, 1'b0);
    repeat (20) step(4'b0000, 1'b0);
    check("t3_nacc", 32'(log_acc_cyc.size()), 32'd8);
    if (log_acc_cyc.size() > 4) begin
      check("t3_4th", 32'(log_acc_cyc[3] - base), 32'd3);
      check("t3_resume", 32'(log_acc_cyc[4] - base), 32'd16);
    end
    check("t3_nres", 32'(log_res_cyc.size()), 32'd8);

    // Accept and credit return for requester 0 in the same cycle.
    do_reset(2);
    clear_logs();
    dx[0] = 16'd100; dy[0] = 16'hFF9C;
    step(4'b0001, 1'b0);
    repeat (14) step(4'b0000, 1'b0);
    repeat (11) step(4'b0001, 1'b0);
    repeat (20) step(4'b0000, 1'b0);
    check("t4_nacc", 32'(log_acc_cyc.size()), 32'd5);
    if (log_res_ph.size() > 0) check("t4_phase", 32'(log_res_ph[0]), 32'h9D80);

    // Flush kills in-flight ops and clears credits.
    do_reset(2);
    clear_logs();
    dx[0] = 16'd0; dy[0] = 16'd100;
    repeat (3) step(4'b0001, 1'b0);
    repeat (5) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    repeat (20) step(4'b0000, 1'b0);
    check("t5_nres", 32'(log_res_cyc.size()), 32'd0);
    clear_logs();
    repeat (6) step(4'b0001, 1'b0);
    repeat (20) step(4'b0000, 1'b0);
    check("t5_nacc", 32'(log_acc_cyc.size()), 32'd4);
    if (log_acc_cyc.size() > 0 && log_res_cyc.size() > 0)
      check("t5_latency", 32'(log_res_cyc[0] - log_acc_cyc[0]), 32'd16);

    // Randomized traffic with occasional flush and a mid-stream reset.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        dx[i] = 16'($urandom);
        dy[i] = 16'($urandom);
      end
      step(4'($urandom), ($urandom_range(0, 39) == 0));
      if (c == 200) begin
        do_reset(2);
        clear_logs();
        step(4'b1010, 1'b0);
        check("t6_nacc", 32'(log_acc_id.size()), 32'd1);
        if (log_acc_id.size() > 0) check("t6_first", 32'(log_acc_id[0]), 32'd1);
      end
    end
    repeat (20) step(4'b0000, 1'b0);

`ifdef CORDIC_SCHED_STATS_EN
    check("stat_ops", stat_ops, 32'(m_ops));
    check("stat_stall", stat_stall, 32'(m_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
